icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction fetch stage and the memory controller's icache port.
- Serves 32-bit instruction words to fetch.
- On a miss, fills one word per line by issuing byte reads through the memory controller's icache request/response handshake.
- The memory controller gives the dcache priority, so any icache byte request may be dropped; this block must re-issue dropped requests.

Parameters:
ADDR_WIDTH, 18, byte address width (memory controller address width)
INDEX_BITS, 4, line index width; 2**INDEX_BITS lines of one 32-bit word each

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
flush  input  1  cancel outstanding fetch (branch redirect); line contents are kept
fetch_req  input  1  fetch request, sampled only in IDLE
fetch_addr  input  ADDR_WIDTH  instruction byte address; bits [1:0] ignored
fetch_valid  output  1  one-cycle pulse; fetch_inst valid
fetch_inst  output  32  instruction word, little-endian
mem_rw_en  output  1  byte read request to memory controller (icache_rw_en)
mem_addr  output  ADDR_WIDTH  byte address of the request (icache_addr)
mem_out_en  input  1  high one cycle after a granted request (icache_out_en)
mem_din  input  8  returned byte, valid when mem_out_en is high (icache_out_data)

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[ADDR_WIDTH-1:INDEX_BITS+2]
  - base = {addr[ADDR_WIDTH-1:2], 2'b00}
- Reset (rst low, asynchronous):
  - state = IDLE; all line valid bits cleared.
  - fetch_valid = 0, fetch_inst = 0.
  - issued_valid = 0, issued_idx = 0, byte buffer = 0.
  - mem_rw_en = 0. Reset mid-fill abandons the fill; no line is written.
- mem_rw_en and mem_addr are combinational from state and registers; mem_addr = 0 whenever mem_rw_en = 0.
- fetch_valid defaults to 0 every cycle; it is high for exactly one cycle per completed fetch.
- IDLE:
  - mem_rw_en = 0. mem_out_en is ignored, which discards any late response after a flush.
  - If fetch_req & ~flush: latch tag, index and base. Compare against the arrays.
  - Hit: next cycle fetch_valid = 1 and fetch_inst = stored word; remain in IDLE (back-to-back hits, one per cycle).
  - Miss: go to FILL with issued_valid = 0.
  - If fetch_req is still high in the cycle fetch_valid is high, it is a new request.
- FILL (one byte request in flight per cycle, pipelined):
  - If mem_out_en & issued_valid: byte buffer[issued_idx] <= mem_din; next index = issued_idx + 1.
  - Otherwise (request dropped by dcache priority, or first cycle): next index = issued_valid ? issued_idx : 0.
  - If next index <= 3: mem_rw_en = 1, mem_addr = base + next index; issued_idx <= next index, issued_valid <= 1.
  - When byte 3 is captured: mem_rw_en = 0 that cycle.
    - Write line {valid=1, tag, word}, where word bits [8k+7:8k] = byte k.
    - Next cycle fetch_valid = 1 and fetch_inst = word. Go to IDLE.
- Uncontended miss timing:
  - Request accepted in cycle 0.
  - Requests issued in cycles 1-4.
  - Bytes captured in cycles 2-5.
  - fetch_valid in cycle 6.
  - Each dropped request adds one cycle.
- flush:
  - In any state, flush forces mem_rw_en = 0 that cycle and returns to IDLE with issued_valid = 0.
  - No line is written and fetch_valid is not raised.
  - A fetch_valid already scheduled for the flush cycle's successor is suppressed.
  - flush does not clear valid bits.
- Byte-address arithmetic is ADDR_WIDTH bits. base + 3 never carries out of the word, because base[1:0] = 0.

Test Plan:
- Cold miss: fetch 0x00010; memory holds 0x13, 0x05, 0x00, 0x00 at 0x10-0x13, with no dcache traffic.
  - Requests go to 0x10, 0x11, 0x12, 0x13 in cycles 1-4.
  - fetch_valid in cycle 6 with fetch_inst = 0x00000513.
- Hit: fetch 0x00010 again.
  - fetch_valid next cycle with 0x00000513; mem_rw_en stays 0.
  - Then fetch 0x00012 → same word (bits [1:0] ignored).
- Dcache steal: during the fill of 0x00020, hold mem_out_en = 0 in the cycle after the byte-1 request.
  - Byte 1 (0x00021) is re-requested the following cycle.
  - The final word is correct; fetch_valid is delayed to cycle 7.
- Conflict eviction: fill 0x00010, then fetch 0x00050 (same index 4, different tag).
  - 0x00050 misses and fills.
  - A later fetch of 0x00010 misses again.
- Flush mid-fill: assert flush after byte 1 is captured during the fill of 0x00030.
  - mem_rw_en = 0 that cycle; the late mem_out_en is ignored; no fetch_valid.
  - A re-fetch of 0x00030 performs a full 4-byte fill.
- Async reset mid-fill: pull rst low between clock edges during FILL.
  - Outputs go to 0 immediately.
  - After release, a previously cached address misses.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// A miss fetches the word one byte at a time through the memory
// controller's icache port. That port can silently drop any request in
// favour of the dcache, so a dropped byte is simply asked for again.
//
// Memory handshake: mem_rw_en is the request valid and mem_addr its byte
// address. There is no ready signal. A request counts as granted exactly
// when mem_out_en is high in the following cycle, and mem_din then holds
// the byte. A request with no mem_out_en after it was dropped. At most
// one request is outstanding at any time.
module icache_direct #(
    parameter int ADDR_WIDTH = 18,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_inst,
    output logic                  mem_rw_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_out_en,
    input  logic [7:0]            mem_din
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Line storage
    logic [LINES-1:0]      line_valid;
    logic [TAG_W-1:0]      tag_arr  [LINES];
    logic [31:0]           data_arr [LINES];

    // Request being served
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [ADDR_WIDTH-1:0] req_base;

    // Fill bookkeeping
    logic                  issued_valid;
    logic [1:0]            issued_idx;
    logic [3:0][7:0]       byte_buf;

    // Combinational helpers
    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]      f_tag;
    logic                  lookup_hit;
    logic                  accept;
    logic                  capture;
    logic                  fill_done;
    logic [2:0]            next_idx;
    logic [31:0]           fill_word;
    logic                  unused_addr_bits;

    assign f_idx      = fetch_addr[INDEX_BITS+1:2];
    assign f_tag      = fetch_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lookup_hit = line_valid[f_idx] && (tag_arr[f_idx] == f_tag);
    assign accept     = (state == IDLE) && fetch_req && !flush;
    // The word being completed: byte 3 arrives straight from memory.
    assign fill_word  = {mem_din, byte_buf[2], byte_buf[1], byte_buf[0]};
    // Instructions are word aligned, so the byte offset is not needed.
    assign unused_addr_bits = ^fetch_addr[1:0];

    // Next state, memory request and fill progress for the current cycle.
    always_comb begin
        next_state = state;
        mem_rw_en  = 1'b0;
        mem_addr   = '0;
        capture    = 1'b0;
        fill_done  = 1'b0;
        next_idx   = 3'd0;
        case (state)
            IDLE: begin
                if (accept && !lookup_hit) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    next_state = IDLE;
                end else begin
                    capture = mem_out_en && issued_valid;
                    if (capture) begin
                        next_idx = {1'b0, issued_idx} + 3'd1;
                    end else if (issued_valid) begin
                        // Previous request was dropped: ask for it again.
                        next_idx = {1'b0, issued_idx};
                    end else begin
                        next_idx = 3'd0;
                    end
                    if (next_idx <= 3'd3) begin
                        mem_rw_en = 1'b1;
                        mem_addr  = req_base + ADDR_WIDTH'(next_idx);
                    end else begin
                        fill_done  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch, fill bookkeeping, valid bits and fetch response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid   <= '0;
            req_tag      <= '0;
            req_idx      <= '0;
            req_base     <= '0;
            issued_valid <= 1'b0;
            issued_idx   <= 2'd0;
            byte_buf     <= '0;
            fetch_valid  <= 1'b0;
            fetch_inst   <= 32'd0;
        end else begin
            fetch_valid <= 1'b0;
            if (accept) begin
                req_tag      <= f_tag;
                req_idx      <= f_idx;
                req_base     <= {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
                issued_valid <= 1'b0;
                if (lookup_hit) begin
                    fetch_valid <= 1'b1;
                    fetch_inst  <= data_arr[f_idx];
                end
            end
            if (state == FILL) begin
                if (flush) begin
                    issued_valid <= 1'b0;
                end else begin
                    if (capture) begin
                        byte_buf[issued_idx] <= mem_din;
                    end
                    if (mem_rw_en) begin
                        issued_idx   <= next_idx[1:0];
                        issued_valid <= 1'b1;
                    end
                    if (fill_done) begin
                        line_valid[req_idx] <= 1'b1;
                        issued_valid        <= 1'b0;
                        fetch_valid         <= 1'b1;
                        fetch_inst          <= fill_word;
                    end
                end
            end
        end
    end

    // Tag and data arrays; only trusted where line_valid is set.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= fill_word;
        end
    end

endmodule
